// File: rtl/fl_layer_pipe.sv
// Camellia FL / FL^-1 layer: two-stage pipeline with a saturating count of completed blocks.
// Latency: 2 clk edges from input handshake to out_valid; sustains 1 block per cycle.
// Backpressure: a stage holds while the stage ahead is full and stalled; in_ready drops only when both are held.
module fl_layer_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [63:0]      in_ke1,
    input  logic [63:0]      in_ke2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [CNT_W-1:0] blk_cnt
);

    function automatic logic [31:0] rol1(input logic [31:0] w);
        return {w[30:0], w[31]};
    endfunction

    logic             s1_vld_q, s1_vld_d;
    logic             s2_vld_q, s2_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Stage 1 holds the half-computed FL / FL^-1 words and the subkey halves stage 2 still needs.
    logic [31:0] s1_xl_q,  s1_xl_d;   // FL XL, reused for YL
    logic [31:0] s1_yr_q,  s1_yr_d;   // FL YR
    logic [31:0] s1_klr_q, s1_klr_d;  // kl_R
    logic [31:0] s1_iyr_q, s1_iyr_d;  // FL^-1 YR, reused for XR'
    logic [31:0] s1_ixl_q, s1_ixl_d;  // FL^-1 XL'
    logic [31:0] s1_kil_q, s1_kil_d;  // ki_L

    logic [127:0] s2_dat_q, s2_dat_d;

    logic s2_load, s1_load, s1_en, s2_en;

    assign s2_load   = !s2_vld_q || out_ready;
    assign s1_load   = !s1_vld_q || s2_load;
    assign in_ready  = s1_load;
    assign s1_en     = s1_load && in_valid;
    assign s2_en     = s2_load && s1_vld_q;

    assign out_valid = s2_vld_q;
    assign out_data  = s2_dat_q;
    assign blk_cnt   = cnt_q;

    // First half of both functions, straight from the input words.
    always_comb begin
        s1_xl_d  = in_data[127:96];
        s1_yr_d  = rol1(in_data[127:96] & in_ke1[63:32]) ^ in_data[95:64];
        s1_klr_d = in_ke1[31:0];
        s1_iyr_d = in_data[31:0];
        s1_ixl_d = in_data[63:32] ^ (in_data[31:0] | in_ke2[31:0]);
        s1_kil_d = in_ke2[63:32];
    end

    // Second half of both functions from the stage-1 registers.
    always_comb begin
        s2_dat_d = {(s1_yr_q | s1_klr_q) ^ s1_xl_q,
                    s1_yr_q,
                    s1_ixl_q,
                    s1_iyr_q ^ rol1(s1_ixl_q & s1_kil_q)};
    end

    // Valid flags advance with the loads; flush wins over any handshake and also freezes the counter.
    always_comb begin
        s1_vld_d = s1_vld_q;
        s2_vld_d = s2_vld_q;
        cnt_d    = cnt_q;
        if (s2_load) s2_vld_d = s1_vld_q;
        if (s1_load) s1_vld_d = in_valid;
        if (s2_vld_q && out_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (flush) begin
            s1_vld_d = 1'b0;
            s2_vld_d = 1'b0;
            cnt_d    = cnt_q;
        end
    end

    // Control state: valid flags and completed-block counter.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            cnt_q    <= cnt_d;
        end
    end

    // Stage-1 data captures only on an accepted input.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s1_xl_q  <= '0;
            s1_yr_q  <= '0;
            s1_klr_q <= '0;
            s1_iyr_q <= '0;
            s1_ixl_q <= '0;
            s1_kil_q <= '0;
        end else if (s1_en) begin
            s1_xl_q  <= s1_xl_d;
            s1_yr_q  <= s1_yr_d;
            s1_klr_q <= s1_klr_d;
            s1_iyr_q <= s1_iyr_d;
            s1_ixl_q <= s1_ixl_d;
            s1_kil_q <= s1_kil_d;
        end
    end

    // Output register holds steady during a stall and is zero out of reset.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            s2_dat_q <= '0;
        end else if (s2_en) begin
            s2_dat_q <= s2_dat_d;
        end
    end

endmodule

// File: tb/tb_fl_layer_pipe.sv
module tb_fl_layer_pipe;

    logic         clk = 1'b0;
    logic         RST = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [127:0] in_data = '0;
    logic [63:0]  in_ke1 = '0;
    logic [63:0]  in_ke2 = '0;

    logic         in_ready, out_valid;
    logic [127:0] out_data;
    logic [7:0]   blk_cnt;

    logic         in_ready2, out_valid2;
    logic [127:0] out_data2;
    logic [1:0]   blk_cnt2;

    int           n_cmp = 0;
    int           n_err = 0;
    int           n_out = 0;
    logic [127:0] sb_q[$];
    logic [127:0] snap;
    int           out_mark;

    fl_layer_pipe #(.CNT_W(8)) u_dut (
        .clk(clk), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ke1(in_ke1), .in_ke2(in_ke2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .blk_cnt(blk_cnt)
    );

    fl_layer_pipe #(.CNT_W(2)) u_dut2 (
        .clk(clk), .RST(RST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_ke1(in_ke1), .in_ke2(in_ke2),
        .out_valid(out_valid2), .out_ready(out_ready),
        .out_data(out_data2), .blk_cnt(blk_cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rotl(input logic [31:0] w);
        return {w[30:0], w[31]};
    endfunction

    // Reference Camellia FL on a 64-bit word.
    function automatic logic [63:0] fl_ref(input logic [63:0] x, input logic [63:0] k);
        logic [31:0] yl, yr;
        yr = x[31:0] ^ rotl(x[63:32] & k[63:32]);
        yl = x[63:32] ^ (yr | k[31:0]);
        return {yl, yr};
    endfunction

    // Reference Camellia FL^-1 on a 64-bit word.
    function automatic logic [63:0] flinv_ref(input logic [63:0] y, input logic [63:0] k);
        logic [31:0] xl, xr;
        xl = y[63:32] ^ (y[31:0] | k[31:0]);
        xr = y[31:0] ^ rotl(xl & k[63:32]);
        return {xl, xr};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] d, input logic [63:0] k1, input logic [63:0] k2);
        in_valid = 1'b1;
        in_data  = d;
        in_ke1   = k1;
        in_ke2   = k2;
    endtask

    task automatic drive_rand();
        drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    endtask

    // Scoreboard: push on accepted input, pop and compare on output handshake.
    always @(negedge clk) begin
        if (!RST || flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                n_out++;
                n_cmp++;
                assert (sb_q.size() != 0) else begin
                    n_err++;
                    $error("FAIL sb_unexpected: observed output %h expected no output", out_data);
                end
                if (sb_q.size() != 0) chk("sb_data", out_data, sb_q.pop_front());
            end
            if (in_valid && in_ready)
                sb_q.push_back({fl_ref(in_data[127:64], in_ke1), flinv_ref(in_data[63:0], in_ke2)});
        end
    end

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        @(posedge clk);
        #2 RST = 1'b1;
        #1 chk("rst_release_in_ready", in_ready, 1);

        // Vector 1 with latency check
        step();
        drive({64'h80000000_00000000, 64'h0}, 64'h80000000_00000000, 64'h0);
        step();
        in_valid = 1'b0;
        chk("v1_one_edge_no_valid", out_valid, 0);
        step();
        chk("v1_two_edge_valid", out_valid, 1);
        chk("v1_data", out_data, {64'h80000001_00000001, 64'h0});
        step();
        chk("v1_drained", out_valid, 0);

        // Vector 2
        drive({64'hFFFFFFFF_00000000, 64'h00000000_FFFFFFFF}, 64'hFFFFFFFF_00000000, 64'hFFFFFFFF_00000000);
        step();
        in_valid = 1'b0;
        step();
        chk("v2_data", out_data, {64'h00000000_FFFFFFFF, 64'hFFFFFFFF_00000000});
        step();
        chk("v2_blk_cnt", blk_cnt, 2);

        // Reset between tests so the back-to-back count starts at zero
        #1 RST = 1'b0;
        step();
        #1 RST = 1'b1;

        // Back-to-back: 10 blocks, outputs on consecutive cycles
        for (int i = 0; i < 10; i++) begin
            step();
            drive_rand();
            if (i >= 2) chk("b2b_out_valid", out_valid, 1);
        end
        step();
        in_valid = 1'b0;
        chk("b2b_out_valid_p10", out_valid, 1);
        step();
        chk("b2b_out_valid_p11", out_valid, 1);
        step();
        chk("b2b_done", out_valid, 0);
        chk("b2b_blk_cnt", blk_cnt, 10);
        chk("b2b_blk_cnt_sat2", blk_cnt2, 3);
        chk("b2b_sb_empty", sb_q.size(), 0);

        // Stall: out_ready low while input keeps offering
        out_mark = n_out;
        step();
        out_ready = 1'b0;
        drive_rand();
        step();
        chk("stall_ready_1st", in_ready, 1);
        drive_rand();
        step();
        drive_rand();
        chk("stall_in_ready_low", in_ready, 0);
        chk("stall_out_valid", out_valid, 1);
        snap = out_data;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("stall_in_ready_hold", in_ready, 0);
            chk("stall_out_data_stable", out_data, snap);
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("stall_drained", out_valid, 0);
        chk("stall_out_count", n_out - out_mark, 3);
        chk("stall_blk_cnt", blk_cnt, 13);
        chk("stall_sb_empty", sb_q.size(), 0);

        // Flush with both stages full, while also offering an input
        out_ready = 1'b0;
        drive_rand();
        step();
        drive_rand();
        step();
        drive_rand();
        flush = 1'b1;
        out_ready = 1'b1;
        #1 chk("flush_in_ready", in_ready, 1);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        chk("flush_blk_cnt", blk_cnt, 13);
        step();
        chk("flush_input_dropped", out_valid, 0);

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        drive_rand();
        step();
        drive_rand();
        step();
        in_valid = 1'b0;
        chk("arst_pre_full", out_valid, 1);
        #2 RST = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_blk_cnt", blk_cnt, 0);
        chk("arst_blk_cnt2", blk_cnt2, 0);
        step();
        #1 RST = 1'b1;
        out_ready = 1'b1;
        #1 chk("arst_in_ready", in_ready, 1);

        // Pipeline still works after the mid-stream reset
        step();
        drive({64'h80000000_00000000, 64'h0}, 64'h80000000_00000000, 64'h0);
        step();
        in_valid = 1'b0;
        step();
        chk("post_rst_data", out_data, {64'h80000001_00000001, 64'h0});
        step();
        chk("post_rst_blk_cnt", blk_cnt, 1);
        chk("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
